// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and ALUOp, stalls on mem_ready and
// counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;

  // Zero is consumed by the datapath (ANDed with PCWriteCond), not here.
  logic unused_zero;
  assign unused_zero = Zero;

  assign state = state_q;

  // State register; reset returns to FETCH and abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Retired-instruction counter, wrapping naturally at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_ONE;
  end

  // Next-state and Moore control decode; every output is held low while reset is high.
  always_comb begin
    state_d     = S_FETCH;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (reset) begin
      retire      = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, scoreboard-based bench for multicycle_control using a narrow
// counter so the wrap-around can be reached quickly.
module tb_multicycle_control;

  localparam int CW = 4;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] JUMP   = 4'd9;
  localparam logic [3:0] ADDIEX = 4'd10;
  localparam logic [3:0] ADDIWB = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Bit positions inside the packed control vector
  localparam int B_PCW  = 16;
  localparam int B_PCWC = 15;
  localparam int B_IORD = 14;
  localparam int B_MRD  = 13;
  localparam int B_MWR  = 12;
  localparam int B_M2R  = 11;
  localparam int B_IRW  = 10;
  localparam int B_ASA  = 9;
  localparam int B_RW   = 8;
  localparam int B_RD   = 7;
  localparam int B_ILL  = 0;

  typedef struct {
    logic [3:0]    st;
    logic [16:0]   ctrl;
    logic [CW-1:0] cnt;
    int            step;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    Op = 6'd0;
  logic          Zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic          IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0]    PCSource, ALUSrcB, ALUOp;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic [16:0]   ctrl_obs;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            step = 0;
  logic [CW-1:0] exp_cnt = '0;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                     ALUOp, illegal_op};

  // Expected control vector for a state, written out from the control table
  function automatic logic [16:0] expCtrl(input logic [3:0] st, input logic mr,
                                          input logic [5:0] op);
    logic [16:0] c;
    c = '0;
    case (st)
      FETCH:  begin c[B_MRD] = 1'b1; c[B_IRW] = mr; c[B_PCW] = mr; c[4:3] = 2'b01; end
      DECODE: begin
        c[4:3] = 2'b11;
        c[B_ILL] = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
      end
      MEMADR: begin c[B_ASA] = 1'b1; c[4:3] = 2'b10; end
      MEMRD:  begin c[B_MRD] = 1'b1; c[B_IORD] = 1'b1; end
      MEMWB:  begin c[B_RW] = 1'b1; c[B_M2R] = 1'b1; end
      MEMWR:  begin c[B_MWR] = 1'b1; c[B_IORD] = 1'b1; end
      EXEC:   begin c[B_ASA] = 1'b1; c[2:1] = 2'b10; end
      ALUWB:  begin c[B_RW] = 1'b1; c[B_RD] = 1'b1; end
      BRANCH: begin c[B_ASA] = 1'b1; c[2:1] = 2'b01; c[B_PCWC] = 1'b1; c[6:5] = 2'b01; end
      JUMP:   begin c[B_PCW] = 1'b1; c[6:5] = 2'b10; end
      ADDIEX: begin c[B_ASA] = 1'b1; c[4:3] = 2'b10; end
      ADDIWB: begin c[B_RW] = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic pushExpect(input logic [3:0] st, input logic [16:0] c,
                            input logic [CW-1:0] cn);
    exp_t e;
    e.st   = st;
    e.ctrl = c;
    e.cnt  = cn;
    e.step = step;
    sb.push_back(e);
    step++;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (state === e.st) else begin
        errors++;
        $error("[TB] FAIL state step %0d: observed=%0d expected=%0d", e.step, state, e.st);
      end
      checks++;
      assert (ctrl_obs === e.ctrl) else begin
        errors++;
        $error("[TB] FAIL ctrl step %0d: observed=%b expected=%b", e.step, ctrl_obs, e.ctrl);
      end
      checks++;
      assert (instr_count === e.cnt) else begin
        errors++;
        $error("[TB] FAIL count step %0d: observed=%0d expected=%0d", e.step, instr_count, e.cnt);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge
  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic z,
                               input logic [3:0] st, input bit retires);
    Op        = op;
    mem_ready = mr;
    Zero      = z;
    pushExpect(st, expCtrl(st, mr, op), exp_cnt);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    if (retires) exp_cnt = exp_cnt + CW'(1);
  endtask

  initial begin
    $display("[TB] start");
    // Asynchronous reset before any clock edge
    #2;
    pushExpect(FETCH, '0, '0);
    checkOutput();
    @(negedge clk);
    pushExpect(FETCH, '0, '0);
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type
    applyStimulus(OP_R, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, EXEC,   1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, ALUWB,  1'b1);

    // lw with two stalled MEMRD cycles
    applyStimulus(OP_LW, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_LW, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_LW, 1'b1, 1'b0, MEMADR, 1'b0);
    applyStimulus(OP_LW, 1'b0, 1'b0, MEMRD,  1'b0);
    applyStimulus(OP_LW, 1'b0, 1'b0, MEMRD,  1'b0);
    applyStimulus(OP_LW, 1'b1, 1'b0, MEMRD,  1'b0);
    applyStimulus(OP_LW, 1'b1, 1'b0, MEMWB,  1'b1);

    // sw with one FETCH stall and one MEMWR stall
    applyStimulus(OP_SW, 1'b0, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, MEMADR, 1'b0);
    applyStimulus(OP_SW, 1'b0, 1'b0, MEMWR,  1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, MEMWR,  1'b1);

    // beq taken and not taken; both retire
    applyStimulus(OP_BEQ, 1'b1, 1'b1, FETCH,  1'b0);
    applyStimulus(OP_BEQ, 1'b1, 1'b1, DECODE, 1'b0);
    applyStimulus(OP_BEQ, 1'b1, 1'b1, BRANCH, 1'b1);
    applyStimulus(OP_BEQ, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_BEQ, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_BEQ, 1'b1, 1'b0, BRANCH, 1'b1);

    // addi
    applyStimulus(OP_ADDI, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_ADDI, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_ADDI, 1'b1, 1'b0, ADDIEX, 1'b0);
    applyStimulus(OP_ADDI, 1'b1, 1'b0, ADDIWB, 1'b1);

    // Illegal opcode: flagged in DECODE, back to FETCH, no retire
    applyStimulus(OP_BAD, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_BAD, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_BAD, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_BAD, 1'b1, 1'b0, DECODE, 1'b0);

    // sw stalled in MEMWR, then asynchronous reset mid-cycle
    applyStimulus(OP_R,  1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_R,  1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_R,  1'b1, 1'b0, EXEC,   1'b0);
    applyStimulus(OP_R,  1'b1, 1'b0, ALUWB,  1'b1);
    applyStimulus(OP_SW, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_SW, 1'b1, 1'b0, MEMADR, 1'b0);
    applyStimulus(OP_SW, 1'b0, 1'b0, MEMWR,  1'b0);
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    pushExpect(FETCH, '0, '0);
    checkOutput();
    @(negedge clk);
    pushExpect(FETCH, '0, '0);
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean R-type after reset, then jumps until the counter wraps to 0
    applyStimulus(OP_R, 1'b1, 1'b0, FETCH,  1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, DECODE, 1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, EXEC,   1'b0);
    applyStimulus(OP_R, 1'b1, 1'b0, ALUWB,  1'b1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(OP_J, 1'b1, 1'b0, FETCH,  1'b0);
      applyStimulus(OP_J, 1'b1, 1'b0, DECODE, 1'b0);
      applyStimulus(OP_J, 1'b1, 1'b0, JUMP,   1'b1);
    end
    applyStimulus(OP_R, 1'b1, 1'b0, FETCH, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle main control FSM for the MIPS datapath. It decodes the instruction-register opcode and sequences fetch, decode, execute, memory and writeback over several cycles. Each cycle it drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU control decoder. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Op  in  6  opcode, IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 use Funct
- state  out  4  current state encoding, for debug
- illegal_op  out  1  unsupported opcode seen in DECODE
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. All others are illegal.
- Outputs are decoded from the state (Moore), except the FETCH write enables, which are gated by mem_ready. Unlisted outputs are 0.
- FETCH (0):
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - Drives IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready=1, otherwise stays.
- DECODE (1):
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw to MEMADR, R to EXEC, beq to BRANCH, j to JUMP, addi to ADDIEX, illegal to FETCH.
  - Drives illegal_op=1 in this cycle when the opcode is illegal.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD (3): MemRead=1, IorD=1. Goes to MEMWB when mem_ready=1, otherwise stays.
- MEMWB (4): RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR (5): MemWrite=1, IorD=1. Goes to FETCH when mem_ready=1, otherwise stays with MemWrite held.
- EXEC (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- ALUWB (7): RegWrite=1, RegDst=1, MemtoReg=0. Goes to FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH; the datapath ANDs PCWriteCond with Zero.
- JUMP (9): PCWrite=1, PCSource=10. Goes to FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
- ADDIWB (11): RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH.
- Encodings 12–15 are unreachable; if entered, the FSM returns to FETCH on the next edge with all outputs 0.
- instr_count increments by 1 on each edge leaving MEMWB, ALUWB, BRANCH, JUMP or ADDIWB, and on the edge leaving MEMWR with mem_ready=1.
  - An illegal opcode does not increment it.
  - It wraps from all-ones to 0.

## Timing
- Reset asserted: state=FETCH, instr_count=0. All control outputs and illegal_op are forced 0 while reset=1, independent of clk.
- First FETCH outputs appear in the cycle after reset deasserts.
- Cycles per instruction with mem_ready constantly 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Other states ignore mem_ready.
- Reset mid-instruction aborts it: no increment, the FSM returns to FETCH, and no partial write completes after reset.
- The state register and counter update only on rising clk.

## Test plan
- R-type (Op=000000), mem_ready=1 -> states 0,1,6,7,0. ALUOp=10 in EXEC. RegWrite=RegDst=1 in ALUWB. instr_count 0→1.
- lw with mem_ready=0 for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0 (8 cycles). MemRead=IorD=1 throughout MEMRD. MemtoReg=1 in MEMWB.
- beq, Zero=1 then Zero=0 -> BRANCH state with ALUOp=01, PCWriteCond=1, PCSource=01 in both cases. Both retire.
- Op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH. instr_count unchanged.
- Reset asserted asynchronously while in MEMWR with mem_ready=0 -> outputs go to 0 immediately. After release: state=0, instr_count=0.
- Counter preloaded (or forced) to all-ones, then j completes -> instr_count=0. PCWrite=1 and PCSource=10 in JUMP.
